// File: rtl/fifo_drain_ctrl_pkg.sv
// Shared types and constants for the capture-FIFO drain controller.
package fifo_drain_ctrl_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [4:0] {
    S_IDLE  = 5'b00001,
    S_READ  = 5'b00010,
    S_LATCH = 5'b00100,
    S_SEND  = 5'b01000,
    S_DONE  = 5'b10000
  } drain_state_t;

endpackage

// File: rtl/fifo_drain_ctrl_if.sv
// FIFO read side plus byte-stream side of the drain controller.
interface fifo_drain_ctrl_if #(
  parameter int DATA_W = 16
);
  logic              full;
  logic              empty;
  logic [DATA_W-1:0] fifo_dout;
  logic              rd_en;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (
    input  full, empty, fifo_dout, tx_ready,
    output rd_en, tx_data, tx_valid
  );

  modport slave (
    output full, empty, fifo_dout, tx_ready,
    input  rd_en, tx_data, tx_valid
  );
endinterface

// File: rtl/fifo_drain_ctrl_word_serializer.sv
// Splits one loaded word into LSB-first bytes on a valid/ready stream.
module fifo_drain_ctrl_word_serializer
  import fifo_drain_ctrl_pkg::*;
#(
  parameter int BYTES = 2
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    load,
  input  logic [BYTES*BYTE_W-1:0] load_data,
  output logic                    last_byte,
  output logic [BYTE_W-1:0]       tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready
);

  localparam int SH_W  = BYTES * BYTE_W;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic [SH_W-1:0]  shift;
  logic [IDX_W-1:0] byte_idx;
  logic             hs;

  assign hs        = tx_valid & tx_ready;
  assign last_byte = hs && (byte_idx == IDX_W'(BYTES - 1));
  // Byte is taken straight from the register so it cannot move during a stall.
  assign tx_data   = shift[BYTE_W-1:0];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shift    <= '0;
      byte_idx <= '0;
      tx_valid <= 1'b0;
    end else if (load) begin
      shift    <= load_data;
      byte_idx <= '0;
      tx_valid <= 1'b1;
    end else if (hs) begin
      shift    <= shift >> BYTE_W;
      byte_idx <= byte_idx + 1'b1;
      if (last_byte) tx_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo_drain_ctrl.sv
// Drains a full capture FIFO word by word into a byte stream until empty.
module fifo_drain_ctrl
  import fifo_drain_ctrl_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int BYTES   = (DATA_W + 7) / 8,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rstn,
  fifo_drain_ctrl_if.master  bus,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] word_count
);

  localparam int SH_W = BYTES * BYTE_W;

  drain_state_t state_q, state_d;
  logic         load;
  logic         wc_clr;
  logic         last_byte;
  logic [SH_W-1:0] load_data;

  assign load_data = SH_W'(bus.fifo_dout);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    bus.rd_en  = 1'b0;
    load       = 1'b0;
    wc_clr     = 1'b0;
    case (state_q)
      S_IDLE: begin
        // full with empty together is inconsistent; wait it out.
        if (bus.full && !bus.empty) begin
          state_d = S_READ;
          wc_clr  = 1'b1;
        end
      end
      S_READ: begin
        if (bus.empty) begin
          state_d = S_DONE;
        end else begin
          bus.rd_en = 1'b1;
          state_d   = S_LATCH;
        end
      end
      S_LATCH: begin
        load    = 1'b1;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (last_byte) state_d = bus.empty ? S_DONE : S_READ;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                                   word_count <= '0;
    else if (wc_clr)                             word_count <= '0;
    else if (load && (word_count != '1))         word_count <= word_count + 1'b1;
  end

  fifo_drain_ctrl_word_serializer #(.BYTES(BYTES)) u_ser (
    .clk       (clk),
    .rstn      (rstn),
    .load      (load),
    .load_data (load_data),
    .last_byte (last_byte),
    .tx_data   (bus.tx_data),
    .tx_valid  (bus.tx_valid),
    .tx_ready  (bus.tx_ready)
  );

endmodule
